// File: rtl/reg_write_sink_if.sv
// Parent-to-child write port: parent drives wr_valid/wr_data, sink returns wr_ready.
interface reg_write_sink_if #(
    parameter int WIDTH = 8
);
    logic             wr_valid;
    logic [WIDTH-1:0] wr_data;
    logic             wr_ready;

    modport master (output wr_valid, output wr_data, input  wr_ready);
    modport slave  (input  wr_valid, input  wr_data, output wr_ready);
endinterface

// File: rtl/reg_write_sink.sv
// Purpose: queue parent writes in a FIFO and commit them to sub_reg one at a time (REG_SINK_ACCUM_EN: commit adds instead of overwrites).
// Latency: 2 edges from accept to sub_reg; peak one commit per 2 cycles.
// Backpressure: wr_ready = !full from registered pointers; a pop from full reopens wr_ready the next cycle.
module reg_write_sink #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic               clock,
    input  logic               reset_n,
    reg_write_sink_if.slave    wr,
    input  logic               apply_en,
    output logic [WIDTH-1:0]   sub_reg,
    output logic [7:0]         commit_count,
    output logic               busy
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {
        IDLE   = 1'b0,
        COMMIT = 1'b1
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic [WIDTH-1:0]  mem [DEPTH];
    logic [WIDTH-1:0]  hold;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic              commit;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty       = (wr_ptr == rd_ptr);
    assign full        = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign wr.wr_ready = !full;
    assign push        = wr.wr_valid && !full;
    assign busy        = !empty || (state_q == COMMIT);

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        commit  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty && apply_en) begin
                    pop     = 1'b1;
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                // apply_en is ignored here so a started commit always lands.
                commit  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= wr.wr_data;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            hold   <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (pop) begin
                hold   <= mem[rd_ptr[AW-1:0]];
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sub_reg      <= '0;
            commit_count <= '0;
        end else if (commit) begin
`ifdef REG_SINK_ACCUM_EN
            sub_reg      <= sub_reg + hold;
`else
            sub_reg      <= hold;
`endif
            commit_count <= commit_count + 8'd1;
        end
    end
endmodule

// File: tb/tb_reg_write_sink.sv
// Directed and random stimulus against a queue-based model of the register sink.
module tb_reg_write_sink;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic             clock;
    logic             reset_n;
    logic             apply_en;
    logic [WIDTH-1:0] sub_reg;
    logic [7:0]       commit_count;
    logic             busy;

    reg_write_sink_if #(.WIDTH(WIDTH)) wif ();

    reg_write_sink #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .wr           (wif.slave),
        .apply_en     (apply_en),
        .sub_reg      (sub_reg),
        .commit_count (commit_count),
        .busy         (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Model: queued writes, one popped value awaiting its commit, committed state.
    logic [WIDTH-1:0] mq[$];
    bit               m_inflight;
    logic [WIDTH-1:0] m_hold;
    logic [WIDTH-1:0] m_sub;
    int unsigned      m_cnt;

    int n_pass;
    int n_checks;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".wr_ready"},     32'(wif.wr_ready),  32'(mq.size() < DEPTH));
        chk({tag, ".busy"},         32'(busy),          32'((mq.size() != 0) || m_inflight));
        chk({tag, ".sub_reg"},      32'(sub_reg),       32'(m_sub));
        chk({tag, ".commit_count"}, 32'(commit_count),  m_cnt % 256);
    endtask

    task automatic model_clear();
        mq.delete();
        m_inflight = 0;
        m_hold     = '0;
        m_sub      = '0;
        m_cnt      = 0;
    endtask

    // Called at a negedge: check, drive, cross one rising edge, advance model, return at next negedge.
    task automatic step(input string tag, input bit v, input logic [WIDTH-1:0] d,
                        input bit en, output bit acc);
        bit do_pop;
        check_outputs(tag);
        wif.wr_valid = v;
        wif.wr_data  = d;
        apply_en     = en;
        acc    = v && (mq.size() < DEPTH);
        do_pop = !m_inflight && (mq.size() != 0) && en;
        @(posedge clock);
        if (m_inflight) begin
`ifdef REG_SINK_ACCUM_EN
            m_sub = m_sub + m_hold;
`else
            m_sub = m_hold;
`endif
            m_cnt++;
            m_inflight = 0;
        end
        if (do_pop) begin
            m_hold     = mq.pop_front();
            m_inflight = 1;
        end
        if (acc) mq.push_back(d);
        @(negedge clock);
    endtask

    task automatic do_reset(input string tag);
        reset_n      = 1'b0;
        wif.wr_valid = 1'b0;
        wif.wr_data  = '0;
        apply_en     = 1'b0;
        model_clear();
        #1;
        chk({tag, ".rst.sub_reg"},      32'(sub_reg),      32'h0);
        chk({tag, ".rst.commit_count"}, 32'(commit_count), 32'h0);
        chk({tag, ".rst.busy"},         32'(busy),         32'h0);
        chk({tag, ".rst.wr_ready"},     32'(wif.wr_ready), 32'h1);
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        bit               acc;
        logic [WIDTH-1:0] val;
        logic [WIDTH-1:0] pend_d;
        bit               pend;
        n_pass   = 0;
        n_checks = 0;
        reset_n      = 1'b0;
        wif.wr_valid = 1'b0;
        wif.wr_data  = '0;
        apply_en     = 1'b0;
        model_clear();
        @(negedge clock);
        do_reset("por");

        // Reset during the COMMIT cycle discards the in-flight write.
        step("rmc0", 1, 8'h5A, 1, acc);
        step("rmc1", 0, 8'h00, 1, acc);
        chk("rmc.busy_in_commit", 32'(busy), 32'h1);
        do_reset("rmc");
        step("rmc2", 0, 8'h00, 1, acc);
        step("rmc3", 0, 8'h00, 1, acc);
        chk("rmc.empty_after", 32'(busy), 32'h0);

        // Single write: visible on sub_reg two edges after accept.
        step("sw0", 1, 8'h3C, 1, acc);
        step("sw1", 0, 8'h00, 1, acc);
        step("sw2", 0, 8'h00, 1, acc);
        chk("sw.sub_reg",      32'(sub_reg),      32'h3C);
        chk("sw.commit_count", 32'(commit_count), 32'h1);
        chk("sw.busy",         32'(busy),         32'h0);

        // Fill and stall with apply_en low, then drain.
        do_reset("fill");
        val = 8'd1;
        for (int i = 0; i < 8; i++) begin
            step("fill", val <= 8'd5, val, 0, acc);
            if (acc) val = val + 8'd1;
        end
        chk("fill.wr_ready", 32'(wif.wr_ready), 32'h0);
        chk("fill.held",     32'(val),          32'h5);
        for (int i = 0; i < 12; i++) begin
            step("drain", val <= 8'd5, val, 1, acc);
            if (acc) val = val + 8'd1;
        end
        chk("drain.count", 32'(commit_count), 32'h5);
`ifdef REG_SINK_ACCUM_EN
        chk("drain.sub_reg", 32'(sub_reg), 32'd15);
`else
        chk("drain.sub_reg", 32'(sub_reg), 32'd5);
`endif

        // Simultaneous push and pop with two entries queued.
        do_reset("pp");
        step("pp0", 1, 8'hA1, 0, acc);
        step("pp1", 1, 8'hA2, 0, acc);
        step("pp2", 1, 8'hA3, 1, acc);
        chk("pp.occupancy_busy", 32'(busy), 32'h1);
        for (int i = 0; i < 8; i++) step("pp", 0, 8'h00, 1, acc);

        // apply_en dropped during COMMIT: commit completes, then no more pops.
        do_reset("gate");
        step("g0", 1, 8'h11, 0, acc);
        step("g1", 1, 8'h22, 0, acc);
        step("g2", 0, 8'h00, 1, acc);
        for (int i = 0; i < 5; i++) step("gate", 0, 8'h00, 0, acc);
        chk("gate.count", 32'(commit_count), 32'h1);
        chk("gate.busy",  32'(busy),         32'h1);
        for (int i = 0; i < 4; i++) step("gate_rel", 0, 8'h00, 1, acc);

        // Overwrite vs accumulate.
        do_reset("acc");
        step("a0", 1, 8'hF0, 1, acc);
        step("a1", 0, 8'h00, 1, acc);
        step("a2", 0, 8'h00, 1, acc);
        chk("acc.first", 32'(sub_reg), 32'hF0);
        step("a3", 1, 8'h20, 1, acc);
        step("a4", 0, 8'h00, 1, acc);
        step("a5", 0, 8'h00, 1, acc);
`ifdef REG_SINK_ACCUM_EN
        chk("acc.second", 32'(sub_reg), 32'h10);
`else
        chk("acc.second", 32'(sub_reg), 32'h20);
`endif

        // Random traffic; a refused write is held until accepted.
        do_reset("rnd");
        pend   = 0;
        pend_d = '0;
        for (int i = 0; i < 400; i++) begin
            bit v;
            bit en;
            if (!pend) begin
                v      = ($urandom_range(0, 3) != 0);
                pend_d = WIDTH'($urandom);
            end else begin
                v = 1;
            end
            en = ($urandom_range(0, 2) != 0);
            step("rnd", v, pend_d, en, acc);
            pend = v && !acc;
        end
        for (int i = 0; i < 12; i++) step("rnd_tail", 0, 8'h00, 1, acc);
        chk("rnd.idle", 32'(busy), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
